// File: rtl/sdram_ch_arbiter.sv
// sdram_ch_arbiter: registered usedw monitor plus a round-robin arbiter that
// picks the next FIFO channel to drain into SDRAM. It runs a req/ack handshake
// with the SDRAM controller and counts the granted burst word by word.
module sdram_ch_arbiter #(
    parameter int NUM_CH    = 10,
    parameter int USEDW_W   = 15,
    parameter int CH_W      = 8,
    parameter int THRESH    = 256,
    parameter int BURST_LEN = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [NUM_CH*USEDW_W-1:0]   usedw_bus,
    input  logic [CH_W-1:0]             mon_ch,
    output logic [USEDW_W-1:0]          mon_usedw,
    output logic                        req,
    input  logic                        ack,
    output logic [CH_W-1:0]             grant_ch,
    output logic                        grant_valid,
    input  logic                        word_en,
    output logic                        burst_done,
    output logic                        underflow
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [USEDW_W-1:0] r_mon_usedw;
    logic               r_req;
    logic               r_grant_valid;
    logic [IDX_W-1:0]   r_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_ptr;
    logic               r_burst_done;
    logic               r_underflow;

    logic               w_req_nxt;
    logic               w_grant_valid_nxt;
    logic [IDX_W-1:0]   w_grant_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               w_burst_done_nxt;
    logic               w_underflow_nxt;

    logic [USEDW_W-1:0] w_mon_sel;
    logic [USEDW_W-1:0] w_gnt_usedw;
    logic [NUM_CH-1:0]  w_elig;
    logic               w_found;
    logic [IDX_W-1:0]   w_winner;

    // Per-channel decode: monitor mux, granted channel's live fill level, eligibility.
    always_comb begin
        w_mon_sel   = '0;
        w_gnt_usedw = '0;
        w_elig      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (mon_ch == CH_W'(k))
                w_mon_sel = usedw_bus[k*USEDW_W +: USEDW_W];
            if (r_grant == IDX_W'(k))
                w_gnt_usedw = usedw_bus[k*USEDW_W +: USEDW_W];
            w_elig[k] = (usedw_bus[k*USEDW_W +: USEDW_W] >= USEDW_W'(THRESH));
        end
    end

    // Round-robin scan starting one past the last served channel; first hit wins.
    always_comb begin
        logic [IDX_W-1:0] w_scan;
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = r_ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            w_scan = (w_scan == IDX_W'(NUM_CH - 1)) ? '0 : w_scan + IDX_W'(1);
            if (!w_found && w_elig[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
        end
    end

    // Monitor readout, one cycle behind mon_ch; out-of-range channels read as 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_mon_usedw <= '0;
        else
            r_mon_usedw <= w_mon_sel;
    end

    // Arbiter next-state and next-register values.
    always_comb begin
        w_state_nxt       = r_state;
        w_req_nxt         = r_req;
        w_grant_valid_nxt = r_grant_valid;
        w_grant_nxt       = r_grant;
        w_cnt_nxt         = r_cnt;
        w_ptr_nxt         = r_ptr;
        w_burst_done_nxt  = 1'b0;
        w_underflow_nxt   = r_underflow;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_found) begin
                    w_grant_nxt       = w_winner;
                    w_req_nxt         = 1'b1;
                    w_grant_valid_nxt = 1'b1;
                    w_state_nxt       = ST_REQ;
                end
            end
            ST_REQ: begin
                // Request is never withdrawn; only ack moves us on.
                if (ack) begin
                    w_req_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (word_en) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_gnt_usedw == '0)
                        w_underflow_nxt = 1'b1;
                    if (r_cnt == CNT_W'(BURST_LEN - 1)) begin
                        w_burst_done_nxt  = 1'b1;
                        w_ptr_nxt         = r_grant;
                        w_grant_valid_nxt = 1'b0;
                        w_state_nxt       = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt       = ST_IDLE;
                w_req_nxt         = 1'b0;
                w_grant_valid_nxt = 1'b0;
            end
        endcase
    end

    // Arbiter state and registered outputs; reset abandons any partial burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_req         <= 1'b0;
            r_grant_valid <= 1'b0;
            r_grant       <= '0;
            r_cnt         <= '0;
            r_ptr         <= IDX_W'(NUM_CH - 1);
            r_burst_done  <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_req         <= w_req_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant       <= w_grant_nxt;
            r_cnt         <= w_cnt_nxt;
            r_ptr         <= w_ptr_nxt;
            r_burst_done  <= w_burst_done_nxt;
            r_underflow   <= w_underflow_nxt;
        end
    end

    assign mon_usedw   = r_mon_usedw;
    assign req         = r_req;
    assign grant_ch    = CH_W'(r_grant);
    assign grant_valid = r_grant_valid;
    assign burst_done  = r_burst_done;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_sdram_ch_arbiter.sv
// Directed bench for sdram_ch_arbiter with a scoreboard of expected grants
// and monitor readouts.
module tb_sdram_ch_arbiter;

    localparam int NUM_CH    = 10;
    localparam int USEDW_W   = 15;
    localparam int CH_W      = 8;
    localparam int THRESH    = 256;
    localparam int BURST_LEN = 256;

    logic                      clk;
    logic                      rst;
    logic                      enable;
    logic [NUM_CH*USEDW_W-1:0] usedw_bus;
    logic [CH_W-1:0]           mon_ch;
    logic [USEDW_W-1:0]        mon_usedw;
    logic                      req;
    logic                      ack;
    logic [CH_W-1:0]           grant_ch;
    logic                      grant_valid;
    logic                      word_en;
    logic                      burst_done;
    logic                      underflow;

    logic [USEDW_W-1:0]        uw [NUM_CH];

    int                        checks;
    int                        errors;
    int                        exp_q [$];
    int                        mon_q [$];

    sdram_ch_arbiter #(
        .NUM_CH   (NUM_CH),
        .USEDW_W  (USEDW_W),
        .CH_W     (CH_W),
        .THRESH   (THRESH),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .usedw_bus  (usedw_bus),
        .mon_ch     (mon_ch),
        .mon_usedw  (mon_usedw),
        .req        (req),
        .ack        (ack),
        .grant_ch   (grant_ch),
        .grant_valid(grant_valid),
        .word_en    (word_en),
        .burst_done (burst_done),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        usedw_bus = '0;
        for (int k = 0; k < NUM_CH; k++)
            usedw_bus[k*USEDW_W +: USEDW_W] = uw[k];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for req, score the grant, handshake, then push n_words words.
    task automatic do_burst(input int n_words, input int zero_from, input bit drop_en);
        int  n;
        int  e;
        bit  early;
        n = 0;
        while (req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_asserted", 32'(req), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (req === 1'b1) begin
            chk("grant_ch", 32'(grant_ch), 32'(e));
            chk("grant_valid_req", 32'(grant_valid), 32'd1);
            repeat (2) @(negedge clk);
            chk("req_held", 32'(req), 32'd1);
            chk("grant_ch_stable", 32'(grant_ch), 32'(e));
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            chk("req_dropped", 32'(req), 32'd0);
            chk("grant_valid_burst", 32'(grant_valid), 32'd1);
            early = 1'b0;
            for (int i = 0; i < n_words; i++) begin
                if (i == 0 && drop_en)
                    enable = 1'b0;
                if (i == zero_from && e >= 0)
                    uw[e] = '0;
                word_en = 1'b1;
                @(negedge clk);
                if (i < BURST_LEN - 1 && burst_done === 1'b1)
                    early = 1'b1;
            end
            word_en = 1'b0;
            chk("no_early_done", 32'(early), 32'd0);
            if (n_words == BURST_LEN) begin
                chk("burst_done", 32'(burst_done), 32'd1);
                chk("grant_valid_end", 32'(grant_valid), 32'd0);
            end
        end
    endtask

    initial begin
        int m;
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        enable  = 1'b0;
        ack     = 1'b0;
        word_en = 1'b0;
        mon_ch  = '0;
        for (int k = 0; k < NUM_CH; k++)
            uw[k] = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant_ch", 32'(grant_ch), 32'd0);
        chk("rst_burst_done", 32'(burst_done), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_mon_usedw", 32'(mon_usedw), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Monitor readout
        uw[3]  = USEDW_W'(16'h1234);
        mon_ch = CH_W'(3);
        mon_q.push_back(32'h1234);
        @(negedge clk);
        m = mon_q.pop_front();
        chk("mon_ch3", 32'(mon_usedw), 32'(m));
        mon_ch = CH_W'(12);
        mon_q.push_back(0);
        @(negedge clk);
        m = mon_q.pop_front();
        chk("mon_ch12", 32'(mon_usedw), 32'(m));
        uw[3] = '0;
        chk("no_req_enable_low", 32'(req), 32'd0);

        // Round-robin among 2, 7, 9 from reset pointer
        uw[2] = USEDW_W'(500);
        uw[7] = USEDW_W'(500);
        uw[9] = USEDW_W'(500);
        exp_q.push_back(2);
        exp_q.push_back(7);
        exp_q.push_back(9);
        exp_q.push_back(2);
        enable = 1'b1;
        repeat (4) do_burst(BURST_LEN, -1, 1'b0);
        uw[2]  = '0;
        uw[7]  = '0;
        uw[9]  = '0;
        enable = 1'b0;
        @(negedge clk);
        chk("rr_pulse_one_cycle", 32'(burst_done), 32'd0);
        chk("rr_idle_req", 32'(req), 32'd0);

        // Threshold boundary on ch4
        uw[4]  = USEDW_W'(THRESH - 1);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("thresh_minus1_req", 32'(req), 32'd0);
        uw[4] = USEDW_W'(THRESH);
        exp_q.push_back(4);
        @(negedge clk);
        chk("thresh_req_next", 32'(req), 32'd1);
        do_burst(BURST_LEN, -1, 1'b0);
        uw[4]  = '0;
        enable = 1'b0;
        @(negedge clk);

        // Single channel 5 with 2-cycle ack delay
        uw[5]  = USEDW_W'(300);
        enable = 1'b1;
        exp_q.push_back(5);
        @(negedge clk);
        chk("ch5_req_next", 32'(req), 32'd1);
        do_burst(BURST_LEN, -1, 1'b0);
        uw[5]  = '0;
        enable = 1'b0;
        @(negedge clk);
        chk("ch5_done_pulse_end", 32'(burst_done), 32'd0);
        chk("ch5_idle_req", 32'(req), 32'd0);
        chk("ch5_no_underflow", 32'(underflow), 32'd0);

        // Underflow on ch1 with enable dropped mid-burst
        uw[1]  = USEDW_W'(400);
        enable = 1'b1;
        exp_q.push_back(1);
        do_burst(BURST_LEN, 10, 1'b1);
        chk("underflow_set", 32'(underflow), 32'd1);
        uw[1] = USEDW_W'(400);
        repeat (5) @(negedge clk);
        chk("underflow_sticky", 32'(underflow), 32'd1);
        chk("no_req_enable_off", 32'(req), 32'd0);
        chk("no_grant_enable_off", 32'(grant_valid), 32'd0);
        uw[1] = '0;

        // Reset mid-burst, then ch0 must win from the reset pointer
        uw[0]  = USEDW_W'(300);
        enable = 1'b1;
        exp_q.push_back(0);
        do_burst(100, -1, 1'b0);
        rst   = 1'b1;
        uw[2] = USEDW_W'(300);
        #1;
        chk("midrst_req", 32'(req), 32'd0);
        chk("midrst_grant_valid", 32'(grant_valid), 32'd0);
        chk("midrst_underflow", 32'(underflow), 32'd0);
        chk("midrst_burst_done", 32'(burst_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(0);
        do_burst(BURST_LEN, -1, 1'b0);
        enable = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_ch_arbiter.md
Name: sdram_ch_arbiter

Overview:
Parametrised, clocked successor to the per-channel FIFO fill-level selector feeding the SDRAM write path. It provides a registered monitor readout of any channel's usedw. It also arbitrates which channel's FIFO is drained into SDRAM next: round-robin among channels whose fill level has reached a threshold. It issues a req/ack handshake to the SDRAM controller and tracks the granted burst word by word until completion.

Parameters:
NUM_CH, 10, number of FIFO channels (2..255)
USEDW_W, 15, width of each channel's usedw count
CH_W, 8, width of channel index ports
THRESH, 256, minimum usedw for a channel to be eligible (1..2^USEDW_W-1)
BURST_LEN, 256, words transferred per grant (>=1, <= THRESH)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous active-high reset
enable  in  1  allows new arbitration; does not abort an active grant
usedw_bus  in  NUM_CH*USEDW_W  concatenated usedw; channel k at bits [k*USEDW_W +: USEDW_W]
mon_ch  in  CH_W  channel index for monitor readout
mon_usedw  out  USEDW_W  registered usedw of mon_ch
req  out  1  burst request to SDRAM controller
ack  in  1  controller accepts request
grant_ch  out  CH_W  channel being requested/served
grant_valid  out  1  high in REQ and BURST states
word_en  in  1  controller pops one word from grant_ch this cycle
burst_done  out  1  one-cycle pulse on last word of burst
underflow  out  1  sticky error: word_en while granted usedw == 0

Behaviour:
- Reset (async assert, sync release): state=IDLE, req=0, grant_ch=0, grant_valid=0, burst_done=0, underflow=0, mon_usedw=0, word counter=0, rr pointer=NUM_CH-1 (first search starts at ch 0).
- Monitor: mon_usedw <= usedw of mon_ch every cycle, 1-cycle latency. mon_ch >= NUM_CH -> 0.
- Eligible(k) = usedw_k >= THRESH. Round-robin search order: ptr+1, ptr+2, ... mod NUM_CH. First eligible channel wins.
- States:
  - IDLE: if enable and any channel eligible: grant_ch <= winner, req <= 1, grant_valid <= 1, go to REQ. Otherwise stay; req=0.
  - REQ: req held high until ack. On cycle with ack=1: req <= 0, counter <= 0, go to BURST. enable is ignored here; no request withdrawal. grant_ch is stable.
  - BURST: each word_en increments counter. If word_en and counter == BURST_LEN-1: burst_done=1 for that next cycle, ptr <= grant_ch, grant_valid <= 0, go to IDLE. word_en outside BURST is ignored.
- Earliest re-request: the IDLE cycle after burst_done. Minimum 1 idle cycle between grants.
- word_en in BURST while usedw of grant_ch == 0: set underflow, which holds until reset. The counter still advances.
- ack in IDLE/BURST: ignored.
- Counter width is clog2(BURST_LEN+1). No wrap within a burst.
- Width rules:
  - grant_ch is zero-extended to CH_W.
  - The usedw comparison is unsigned.
- Usedw values are sampled live, not snapshotted; only the winner is latched.
- Reset asserted mid-REQ/BURST: immediate return to reset values. Partial burst is not resumed.

Test Plan:
- Reset then mon_ch=3, usedw ch3=0x1234 -> mon_usedw=0x1234 one cycle later; mon_ch=12 -> mon_usedw=0.
- enable=1, only ch5 usedw=300 -> req=1, grant_ch=5 next cycle. ack 2 cycles later -> req drops. 256 word_en -> burst_done pulse on the last, grant_valid=0.
- ch2, ch7, ch9 all at 500, enable held, each burst completed -> grant order 2,7,9,2. The pointer wraps correctly.
- ch4 usedw=255 (THRESH-1) -> no req; raise to 256 -> req next cycle.
- In BURST on ch1, deassert enable and drive usedw ch1=0 with word_en -> burst still completes, underflow=1 and sticky; no new req afterwards while enable=0.
- Assert rst mid-BURST after 100 words -> req=0, grant_valid=0, underflow=0 immediately. After release with ch0 eligible, grant_ch=0.
